// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared UART receiver definitions (frame width, default bit period, FSM encoding).
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_rx_pkg;
    localparam int UART_DATA_BITS    = 8;
    localparam int UART_CLKS_PER_BIT = 16;
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_HIGH
    } state_e;
endpackage

// File: rtl/uart_sync2.sv
// uart_sync2: two-flop synchroniser that resets to the idle-high line level.
module uart_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic [1:0] sync_q;
    always_ff @(posedge clk) begin
        if (rst) sync_q <= 2'b11;
        else     sync_q <= {sync_q[0], d};
    end
    assign q = sync_q[1];
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 LSB-first UART receiver with one-cycle valid / framing_err strobes.
// Define UART_RX_PARITY_EN to add an even-parity bit and a parity_err strobe.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic                      clk1,
    input  logic                      rst,
    input  logic                      rx_in,
    output logic [UART_DATA_BITS-1:0] data,
    output logic                      valid,
    output logic                      framing_err,
`ifdef UART_RX_PARITY_EN
    output logic                      parity_err,
`endif
    output logic                      busy
);
    localparam int HALF_BIT = (CLKS_PER_BIT - 1) / 2;
    localparam int CW       = $clog2(CLKS_PER_BIT);

    logic                      rx_s;
    state_e                    state_q, state_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [2:0]                bit_idx_q, bit_idx_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d, data_q, data_d;
    logic                      valid_q, valid_d, ferr_q, ferr_d;
    logic                      cnt_end, cnt_half;
`ifdef UART_RX_PARITY_EN
    logic                      par_bad_q, par_bad_d, perr_q, perr_d;
`endif

    uart_sync2 u_sync (.clk(clk1), .rst(rst), .d(rx_in), .q(rx_s));

    assign cnt_end  = cnt_q == CW'(CLKS_PER_BIT - 1);
    assign cnt_half = cnt_q == CW'(HALF_BIT);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CW'(1);
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d = par_bad_q;
        perr_d    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                cnt_d   = '0;
                state_d = rx_s ? IDLE : START;
            end
            START: if (cnt_half) begin
                cnt_d     = '0;
                bit_idx_d = '0;
                state_d   = rx_s ? IDLE : DATA;
            end
            DATA: if (cnt_end) begin
                cnt_d     = '0;
                shift_d   = {rx_s, shift_q[UART_DATA_BITS-1:1]};
                bit_idx_d = bit_idx_q + 3'd1;
`ifdef UART_RX_PARITY_EN
                if (bit_idx_q == 3'(UART_DATA_BITS - 1)) state_d = PARITY;
`else
                if (bit_idx_q == 3'(UART_DATA_BITS - 1)) state_d = STOP;
`endif
            end
`ifdef UART_RX_PARITY_EN
            PARITY: if (cnt_end) begin
                cnt_d     = '0;
                par_bad_d = rx_s ^ (^shift_q);
                state_d   = STOP;
            end
`endif
            STOP: if (cnt_end) begin
                cnt_d = '0;
                // A low stop bit reports only a framing error, even if parity also failed.
                if (rx_s) begin
`ifdef UART_RX_PARITY_EN
                    perr_d  = par_bad_q;
                    valid_d = !par_bad_q;
                    data_d  = par_bad_q ? data_q : shift_q;
`else
                    valid_d = 1'b1;
                    data_d  = shift_q;
`endif
                    state_d = IDLE;
                end else begin
                    ferr_d  = 1'b1;
                    state_d = WAIT_HIGH;
                end
            end
            WAIT_HIGH: begin
                cnt_d   = '0;
                state_d = rx_s ? IDLE : WAIT_HIGH;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= par_bad_d;
            perr_q    <= perr_d;
`endif
        end
    end

    assign data        = data_q;
    assign valid       = valid_q;
    assign framing_err = ferr_q;
    assign busy        = state_q != IDLE;
`ifdef UART_RX_PARITY_EN
    assign parity_err  = perr_q;
`endif
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames into uart_rx at CLKS_PER_BIT=4 with hand-computed expectations.
// Parity cases run only when UART_RX_PARITY_EN is defined.
module tb_uart_rx;
    localparam int CPB = 4;

    logic       clk1 = 1'b0;
    logic       rst = 1'b1;
    logic       rx_in = 1'b1;
    logic [7:0] data;
    logic       valid, framing_err, busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
    int         pcnt = 0;
`endif

    int         n_vec = 0, n_err = 0;
    int         cyc = 0, vcnt = 0, fcnt = 0, both = 0, vtime = 0;
    int         t0, v0, f0, lat;
    logic [7:0] vlog [64];

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk1(clk1),
        .rst(rst),
        .rx_in(rx_in),
        .data(data),
        .valid(valid),
        .framing_err(framing_err),
`ifdef UART_RX_PARITY_EN
        .parity_err(parity_err),
`endif
        .busy(busy)
    );

    always #5 clk1 = ~clk1;

    always @(posedge clk1) cyc <= cyc + 1;

    always @(negedge clk1) begin
        if (valid) begin
            vlog[vcnt % 64] = data;
            vtime = cyc;
            vcnt++;
        end
        if (framing_err) fcnt++;
        if (valid && framing_err) both++;
`ifdef UART_RX_PARITY_EN
        if (parity_err) pcnt++;
`endif
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk1);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b, input logic stop_b);
        rx_in = 1'b0;
        step(CPB);
        for (int i = 0; i < 8; i++) begin
            rx_in = b[i];
            step(CPB);
        end
`ifdef UART_RX_PARITY_EN
        rx_in = ^b;
        step(CPB);
`endif
        rx_in = stop_b;
        step(CPB);
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic send_badpar(input logic [7:0] b);
        rx_in = 1'b0;
        step(CPB);
        for (int i = 0; i < 8; i++) begin
            rx_in = b[i];
            step(CPB);
        end
        rx_in = ~^b;
        step(CPB);
        rx_in = 1'b1;
        step(CPB);
    endtask
`endif

    initial begin
        step(2);
        check("rst_data", data, 8'h00);
        check("rst_valid", valid, 1'b0);
        check("rst_ferr", framing_err, 1'b0);
        check("rst_busy", busy, 1'b0);
        rst = 1'b0;
        step(3);

        t0 = cyc;
        v0 = vcnt;
        send(8'h08, 1'b1);
        step(4);
        lat = vtime - t0;
        check("t1_lat_window", (lat >= 40 && lat <= 42), 1'b1);
        check("t1_vcnt", vcnt - v0, 1);
        check("t1_data", data, 8'h08);
        check("t1_ferr", fcnt, 0);

        v0 = vcnt;
        send(8'hA5, 1'b1);
        send(8'h3C, 1'b1);
        step(4);
        check("t2_vcnt", vcnt - v0, 2);
        check("t2_first", vlog[v0 % 64], 8'hA5);
        check("t2_second", vlog[(v0 + 1) % 64], 8'h3C);

        v0 = vcnt;
        f0 = fcnt;
        rx_in = 1'b0;
        step(1);
        rx_in = 1'b1;
        step(4);
        check("t3_busy", busy, 1'b0);
        step(40);
        check("t3_vcnt", vcnt - v0, 0);
        check("t3_ferr", fcnt - f0, 0);

        v0 = vcnt;
        f0 = fcnt;
        send(8'h55, 1'b0);
        step(20);
        check("t4_ferr", fcnt - f0, 1);
        check("t4_novalid", vcnt - v0, 0);
        check("t4_data_kept", data, 8'h3C);
        rx_in = 1'b1;
        step(8);
        check("t4_idle", busy, 1'b0);
        send(8'h81, 1'b1);
        step(4);
        check("t4_data", data, 8'h81);
        check("t4_vcnt", vcnt - v0, 1);
        check("t4_ferr_once", fcnt - f0, 1);

        v0 = vcnt;
        rx_in = 1'b0;
        step(CPB);
        for (int i = 0; i < 4; i++) begin
            rx_in = i[0];
            step(CPB);
        end
        rx_in = 1'b1;
        step(2);
        check("t5_busy_mid", busy, 1'b1);
        rst = 1'b1;
        step(1);
        check("t5_valid", valid, 1'b0);
        check("t5_busy", busy, 1'b0);
        check("t5_data", data, 8'h00);
        rst = 1'b0;
        step(4);
        send(8'hFF, 1'b1);
        step(4);
        check("t5_rx_ff", data, 8'hFF);
        check("t5_vcnt", vcnt - v0, 1);

`ifdef UART_RX_PARITY_EN
        v0 = vcnt;
        f0 = pcnt;
        send(8'h07, 1'b1);
        step(4);
        check("t6_good_data", data, 8'h07);
        check("t6_good_vcnt", vcnt - v0, 1);
        check("t6_good_perr", pcnt - f0, 0);
        v0 = vcnt;
        send_badpar(8'h07);
        step(4);
        check("t6_bad_perr", pcnt - f0, 1);
        check("t6_bad_vcnt", vcnt - v0, 0);
        check("t6_bad_data", data, 8'h07);
`endif

        check("excl_valid_ferr", both, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
